// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one apb_m command port between NREQ requesters.
// It tracks the APB SETUP/ENABLE phases and returns completion and read data to the granted requester.
module apb_req_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 4,
  parameter int DW   = 8,
  parameter int TOUT = 15
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  input  logic [NREQ-1:0]    req_wr,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic [2:0]         grant_id,
  output logic               busy,
  output logic               tout_err,
  output logic [AW-1:0]      m_addr,
  output logic [DW-1:0]      m_wdata,
  output logic               m_wr,
  output logic               m_newd,
  input  logic               psel,
  input  logic               penable,
  input  logic               pready,
  input  logic [DW-1:0]      prdata
);

  localparam int CW = $clog2(TOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [2:0]        rr_q, rr_d;
  logic [2:0]        grant_q, grant_d;
  logic [AW-1:0]     m_addr_q, m_addr_d;
  logic [DW-1:0]     m_wdata_q, m_wdata_d;
  logic              m_wr_q, m_wr_d;
  logic              m_newd_q, m_newd_d;
  logic [NREQ-1:0]   req_ready_q, req_ready_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic              busy_q, busy_d;
  logic              tout_err_q, tout_err_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done;

  // Grant selection: lowest pending index above rr, else lowest pending overall.
  logic [NREQ-1:0]           above_rr;
  logic [NREQ-1:0]           masked;
  logic [NREQ-1:0]           cand;
  logic [NREQ-1:0]           gnt_oh;
  logic [AW-1:0][NREQ-1:0]   addr_col;
  logic [DW-1:0][NREQ-1:0]   wdata_col;
  logic [2:0][NREQ-1:0]      idx_col;
  logic [AW-1:0]             sel_addr;
  logic [DW-1:0]             sel_wdata;
  logic [2:0]                sel_idx;
  logic                      sel_wr;

  genvar gi, gb;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign above_rr[gi] = (3'(gi) > rr_q);
      for (gb = 0; gb < AW; gb++) begin : g_addr
        assign addr_col[gb][gi] = req_addr[gi*AW + gb];
      end
      for (gb = 0; gb < DW; gb++) begin : g_wdata
        assign wdata_col[gb][gi] = req_wdata[gi*DW + gb];
      end
      for (gb = 0; gb < 3; gb++) begin : g_idx
        assign idx_col[gb][gi] = (((gi >> gb) & 1) != 0);
      end
    end
    for (gb = 0; gb < AW; gb++) begin : g_sel_addr
      assign sel_addr[gb] = |(gnt_oh & addr_col[gb]);
    end
    for (gb = 0; gb < DW; gb++) begin : g_sel_wdata
      assign sel_wdata[gb] = |(gnt_oh & wdata_col[gb]);
    end
    for (gb = 0; gb < 3; gb++) begin : g_sel_idx
      assign sel_idx[gb] = |(gnt_oh & idx_col[gb]);
    end
  endgenerate

  assign masked = req_valid & above_rr;
  assign cand   = (|masked) ? masked : req_valid;
  assign gnt_oh = cand & (~cand + NREQ'(1));
  assign sel_wr = |(gnt_oh & req_wr);

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    m_wr_d      = m_wr_q;
    m_newd_d    = 1'b0;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          state_d     = S_ISSUE;
          grant_d     = sel_idx;
          m_addr_d    = sel_addr;
          m_wdata_d   = sel_wdata;
          m_wr_d      = sel_wr;
          m_newd_d    = 1'b1;
          req_ready_d = gnt_oh;
        end
      end
      S_ISSUE: begin
        m_newd_d = 1'b1;
        if (psel && penable) begin
          m_newd_d = 1'b0;
          // A zero-wait completer finishes in the first ENABLE cycle; catch it here.
          if (pready) done = 1'b1;
          else        state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (psel && penable && pready) done = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (done) begin
      state_d     = S_IDLE;
      rr_d        = grant_q;
      rsp_valid_d = NREQ'(1) << grant_q;
      rsp_rdata_d = m_wr_q ? '0 : prdata;
    end
  end

  always_comb begin
    if (state_q == S_IDLE)          cnt_d = '0;
    else if (cnt_q != CW'(TOUT))    cnt_d = cnt_q + CW'(1);
    else                            cnt_d = cnt_q;
    tout_err_d = tout_err_q | (cnt_d == CW'(TOUT));
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= S_IDLE;
      rr_q        <= 3'(NREQ - 1);
      grant_q     <= '0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_wr_q      <= 1'b0;
      m_newd_q    <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
      tout_err_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      m_wr_q      <= m_wr_d;
      m_newd_q    <= m_newd_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      busy_q      <= busy_d;
      tout_err_q  <= tout_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;
  assign tout_err  = tout_err_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_wr      = m_wr_q;
  assign m_newd    = m_newd_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: a small apb_m-like master answers m_newd,
// requesters drop req_valid after req_ready, and every check is an immediate assertion.
module tb_apb_req_arbiter;

  logic        clk, rst;
  logic [3:0]  req_valid;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wr;
  logic [3:0]  req_ready, rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [2:0]  grant_id;
  logic        busy, tout_err;
  logic [3:0]  m_addr;
  logic [7:0]  m_wdata;
  logic        m_wr, m_newd;
  logic        psel, penable, pready;
  logic [7:0]  prdata;

  int n_cmp = 0;
  int n_err = 0;
  int lat;

  apb_req_arbiter dut (
    .pclk(clk), .preset(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata), .req_wr(req_wr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .grant_id(grant_id), .busy(busy), .tout_err(tout_err),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wr(m_wr), .m_newd(m_newd),
    .psel(psel), .penable(penable), .pready(pready), .prdata(prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // apb_m stand-in: IDLE -> SETUP on newd, SETUP -> ENABLE, ENABLE held until pready.
  always @(posedge clk) begin
    if (rst) begin
      psel    <= 1'b0;
      penable <= 1'b0;
    end else if (!psel) begin
      if (m_newd) psel <= 1'b1;
    end else if (!penable) begin
      penable <= 1'b1;
    end else if (pready) begin
      psel    <= 1'b0;
      penable <= 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; requesters withdraw once their command is latched.
  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~req_ready;
  endtask

  task automatic wait_grant(input int id, input logic [3:0] a, input logic [7:0] d,
                            input logic w, input string tag, output int n);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    n = 0;
    do begin
      tick();
      n++;
    end while (req_ready == 4'b0 && n < 20);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(oh));
    chk({tag, "_grant_id"}, 32'(grant_id), 32'(id));
    chk({tag, "_m_addr"}, 32'(m_addr), 32'(a));
    chk({tag, "_m_wdata"}, 32'(m_wdata), 32'(d));
    chk({tag, "_m_wr"}, 32'(m_wr), 32'(w));
    chk({tag, "_m_newd"}, 32'(m_newd), 32'(1));
    chk({tag, "_busy"}, 32'(busy), 32'(1));
  endtask

  task automatic wait_rsp(input int id, input logic [7:0] rd, input string tag);
    logic [3:0] oh;
    int n;
    int early;
    oh = 4'b0001 << id;
    n = 0;
    early = 0;
    do begin
      tick();
      n++;
      if (rsp_valid == 4'b0 && req_ready != 4'b0) early++;
    end while (rsp_valid == 4'b0 && n < 60);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(oh));
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'(rd));
    chk({tag, "_busy_done"}, 32'(busy), 32'(0));
    chk({tag, "_newd_done"}, 32'(m_newd), 32'(0));
    chk({tag, "_no_ready_in_flight"}, 32'(early), 32'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(0));
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'(0));
    chk({tag, "_grant_id"}, 32'(grant_id), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_tout_err"}, 32'(tout_err), 32'(0));
    chk({tag, "_m_bus"}, {m_wr, m_newd, m_addr, m_wdata}, 32'(0));
  endtask

  initial begin
    rst = 1'b1; req_valid = 4'b0; req_addr = 16'h0; req_wdata = 32'h0; req_wr = 4'b0;
    pready = 1'b0; prdata = 8'h00;
    tick(); tick();
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Single write from requester 1, zero-wait completer; write returns rdata 0.
    req_addr = 16'h0030; req_wdata = 32'h0000A500; req_wr = 4'b0010;
    pready = 1'b1; prdata = 8'hFF; req_valid = 4'b0010;
    wait_grant(1, 4'h3, 8'hA5, 1'b1, "wr1", lat);
    chk("wr1_grant_latency", 32'(lat), 32'(1));
    tick();
    chk("wr1_setup_newd", {29'b0, psel, penable, m_newd}, 32'b101);
    wait_rsp(1, 8'h00, "wr1");
    $display("txn wr1: req1 write addr=3 data=A5 completed");

    // Round-robin contention after reset.
    rst = 1'b1; tick(); rst = 1'b0;
    req_addr = 16'hBA98; req_wdata = 32'h33323130; req_wr = 4'b1111;
    req_valid = 4'b0101;
    wait_grant(0, 4'h8, 8'h30, 1'b1, "rr_a", lat);
    wait_rsp(0, 8'h00, "rr_a");
    wait_grant(2, 4'hA, 8'h32, 1'b1, "rr_b", lat);
    chk("rr_b_idle_gap", 32'(lat), 32'(1));
    wait_rsp(2, 8'h00, "rr_b");
    req_valid = 4'b0101;
    wait_grant(0, 4'h8, 8'h30, 1'b1, "rr_c", lat);
    req_valid = 4'b0011;
    wait_rsp(0, 8'h00, "rr_c");
    wait_grant(1, 4'h9, 8'h31, 1'b1, "rr_d", lat);
    wait_rsp(1, 8'h00, "rr_d");
    wait_grant(0, 4'h8, 8'h30, 1'b1, "rr_e", lat);
    wait_rsp(0, 8'h00, "rr_e");
    $display("txn rr: grant order 0,2,0,1,0 checked");

    // Read from requester 3 with three low-pready ENABLE cycles.
    pready = 1'b0; prdata = 8'h5E; req_addr = 16'hCA98; req_wr = 4'b0111;
    req_valid = 4'b1000;
    wait_grant(3, 4'hC, 8'h33, 1'b0, "rd3", lat);
    lat = 0;
    while (!penable && lat < 10) begin tick(); lat++; end
    chk("rd3_enable_reached", 32'(penable), 32'(1));
    tick(); tick();
    chk("rd3_still_waiting", {30'b0, busy, |rsp_valid}, 32'b10);
    pready = 1'b1;
    wait_rsp(3, 8'h5E, "rd3");
    tick();
    chk("rd3_pulse_once", 32'(rsp_valid), 32'(0));
    chk("rd3_rdata_hold", 32'(rsp_rdata), 32'h5E);
    $display("txn rd3: req3 read addr=C returned 5E");

    // Timeout on requester 2: pready low for 20 cycles.
    pready = 1'b0; req_valid = 4'b0100;
    wait_grant(2, 4'hA, 8'h32, 1'b1, "tout", lat);
    repeat (14) tick();
    chk("tout_before", 32'(tout_err), 32'(0));
    tick();
    chk("tout_rise", 32'(tout_err), 32'(1));
    repeat (5) tick();
    chk("tout_sticky", {29'b0, tout_err, busy, |rsp_valid}, 32'b110);
    pready = 1'b1;
    wait_rsp(2, 8'h00, "tout");
    chk("tout_after_done", 32'(tout_err), 32'(1));
    $display("txn tout: req2 write stalled, tout_err raised and held");

    // Reset while in WAIT abandons the transfer; requester 0 wins afterwards.
    pready = 1'b0; prdata = 8'h77; req_wr = 4'b0101; req_valid = 4'b0010;
    wait_grant(1, 4'h9, 8'h31, 1'b0, "rst_mid", lat);
    repeat (4) tick();
    chk("rst_mid_in_wait", {30'b0, busy, m_newd}, 32'b10);
    rst = 1'b1; tick();
    chk_reset_outputs("rst_mid");
    rst = 1'b0;
    pready = 1'b1; req_valid = 4'b0011;
    wait_grant(0, 4'h8, 8'h30, 1'b1, "post_rst_a", lat);
    wait_rsp(0, 8'h00, "post_rst_a");
    wait_grant(1, 4'h9, 8'h31, 1'b0, "post_rst_b", lat);
    wait_rsp(1, 8'h77, "post_rst_b");
    $display("txn rst_mid: abandoned read, then req0 write and req1 read");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
